// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request ports and the single RAM port seen by the arbiter
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data priority with bounded fetch starvation and a grant watchdog
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IGNT, DGNT, RESP, ABRT} state_t;
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t state, state_n;
  logic [SW-1:0] streak;
  logic [WW-1:0] wd;
  logic src_d, wr, rd, dsel, expire;
  assign dsel   = (bus.dREN | bus.dWEN) && !(bus.iREN && streak == SW'(MAX_DSTREAK));
  assign expire = bus.ramstate == 2'd3 || wd == WW'(TIMEOUT - 1);
  always_ff @(posedge CLK or posedge nRST)
    if (nRST) state <= IDLE;
    else      state <= state_n;
  // enables decode straight from state so an async reset drops them at once
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = dsel ? DGNT : bus.iREN ? IGNT : IDLE;
      IGNT, DGNT: state_n = bus.ramstate == 2'd2 ? RESP : expire ? ABRT : state;
      default:    state_n = IDLE;
    endcase
    bus.ihit   = state == RESP && !src_d;
    bus.dhit   = state == RESP && src_d;
    bus.err    = state == ABRT;
    bus.ramREN = state == IGNT || (state == DGNT && rd && !wr);
    bus.ramWEN = state == DGNT && wr;
  end
  always_ff @(posedge CLK or posedge nRST)
    if (nRST) begin
      streak       <= '0;
      wd           <= '0;
      src_d        <= 1'b0;
      wr           <= 1'b0;
      rd           <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
      bus.iload    <= '0;
      bus.dload    <= '0;
    end else if (state == IDLE) begin
      streak <= (!bus.iREN || state_n == IGNT) ? '0 :
                (state_n == DGNT && streak != SW'(MAX_DSTREAK)) ? streak + 1'b1 : streak;
      wd     <= '0;
      if (state_n == DGNT) begin
        bus.ramaddr  <= bus.daddr;
        bus.ramstore <= bus.dstore;
        wr           <= bus.dWEN;
        rd           <= bus.dREN;
        src_d        <= 1'b1;
      end
      if (state_n == IGNT) begin
        bus.ramaddr <= bus.iaddr;
        src_d       <= 1'b0;
      end
    end else if (state == IGNT || state == DGNT) begin
      wd <= wd + 1'b1;
      if (state_n == RESP && src_d)  bus.dload <= bus.ramload;
      if (state_n == RESP && !src_d) bus.iload <= bus.ramload;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for mem_arbiter
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST;
  int errors = 0;
  int checks = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    int nd_before, nd_after, icyc;
    nRST = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
    tick(); tick();
    check("rst_ihit", bus.ihit, 0);
    check("rst_dhit", bus.dhit, 0);
    check("rst_err", bus.err, 0);
    check("rst_ren", bus.ramREN, 0);
    check("rst_wen", bus.ramWEN, 0);
    check("rst_addr", bus.ramaddr, 0);
    check("rst_iload", bus.iload, 0);
    nRST = 1'b0;
    tick();
    // fetch with immediate ACCESS
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
    tick();
    check("f_ren1", bus.ramREN, 1);
    check("f_addr1", bus.ramaddr, 32'h40);
    tick();
    check("f_ihit2", bus.ihit, 1);
    check("f_iload2", bus.iload, 32'hDEADBEEF);
    check("f_ren2", bus.ramREN, 0);
    bus.iREN = 0;
    tick();
    check("f_ihit3", bus.ihit, 0);
    check("f_iload_hold", bus.iload, 32'hDEADBEEF);
    // data write wins over pending fetch, 3 BUSY cycles
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'h12345678;
    bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = 2'd1;
    tick();
    check("d_wen1", bus.ramWEN, 1);
    check("d_ren1", bus.ramREN, 0);
    check("d_addr1", bus.ramaddr, 32'h100);
    check("d_store1", bus.ramstore, 32'h12345678);
    tick();
    bus.daddr = 32'h200;
    tick();
    check("d_addr_latched", bus.ramaddr, 32'h100);
    check("d_wen3", bus.ramWEN, 1);
    tick();
    bus.ramstate = 2'd2;
    tick();
    check("d_dhit5", bus.dhit, 1);
    check("d_ihit5", bus.ihit, 0);
    bus.dWEN = 0;
    tick();
    check("d_ren6", bus.ramREN, 0);
    bus.ramload = 32'h55;
    tick();
    check("i_ren7", bus.ramREN, 1);
    check("i_addr7", bus.ramaddr, 32'h80);
    tick();
    check("i_ihit8", bus.ihit, 1);
    check("i_iload8", bus.iload, 32'h55);
    bus.iREN = 0;
    tick();
    // streak limit: 4 data hits, then fetch, then data resumes
    bus.dREN = 1; bus.daddr = 32'h10; bus.iREN = 1; bus.iaddr = 32'hC0;
    bus.ramload = 32'hA5A5_0001;
    nd_before = 0; nd_after = 0; icyc = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.ihit) begin
        icyc = c;
        bus.iREN = 0;
      end else if (bus.dhit) begin
        if (icyc < 0) nd_before++;
        else nd_after++;
      end
    end
    bus.dREN = 0;
    check("s_before", nd_before, 4);
    check("s_icyc", icyc, 14);
    check("s_after", nd_after, 5);
    check("s_dload", bus.dload, 32'hA5A5_0001);
    tick();
    // watchdog abort on a stuck BUSY, then retry
    bus.iREN = 1; bus.iaddr = 32'h300; bus.ramstate = 2'd1;
    for (int c = 1; c <= 16; c++) tick();
    check("w_err16", bus.err, 0);
    tick();
    check("w_err17", bus.err, 1);
    check("w_ihit17", bus.ihit, 0);
    check("w_ren17", bus.ramREN, 0);
    tick();
    check("w_err18", bus.err, 0);
    check("w_ren18", bus.ramREN, 0);
    tick();
    check("w_regrant19", bus.ramREN, 1);
    bus.ramstate = 2'd2; bus.ramload = 32'h77;
    tick();
    check("w_ihit20", bus.ihit, 1);
    check("w_iload20", bus.iload, 32'h77);
    bus.iREN = 0;
    tick();
    // RAM ERROR during a data read, retry completes
    bus.dREN = 1; bus.daddr = 32'h44; bus.ramstate = 2'd1;
    tick();
    check("e_ren1", bus.ramREN, 1);
    bus.ramstate = 2'd3;
    tick();
    check("e_err2", bus.err, 1);
    check("e_dhit2", bus.dhit, 0);
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE;
    tick();
    check("e_err3", bus.err, 0);
    check("e_dhit3", bus.dhit, 0);
    tick();
    check("e_ren4", bus.ramREN, 1);
    tick();
    check("e_dhit5", bus.dhit, 1);
    check("e_dload5", bus.dload, 32'hCAFE);
    bus.dREN = 0;
    tick();
    // async reset mid-grant
    bus.dWEN = 1; bus.daddr = 32'h88; bus.dstore = 32'h99; bus.ramstate = 2'd1;
    tick();
    check("r_wen1", bus.ramWEN, 1);
    #2;
    nRST = 1'b1;
    #1;
    check("r_wen_async", bus.ramWEN, 0);
    check("r_addr_async", bus.ramaddr, 0);
    bus.dWEN = 0;
    tick();
    nRST = 1'b0;
    bus.dWEN = 1; bus.ramstate = 2'd2;
    tick();
    check("r_wen_again", bus.ramWEN, 1);
    check("r_addr_again", bus.ramaddr, 32'h88);
    tick();
    check("r_dhit", bus.dhit, 1);
    bus.dWEN = 0;
    tick();
    check("r_idle", bus.ramWEN | bus.ramREN, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
